cvi_stream_rx: RTL

Clocked-video receiver: accepts a continuous pixel stream in the same clocked-video format the video outputs drive (24-bit RGB, datavalid, h_sync, v_sync) and repacks it into a backpressurable Avalon-ST packet stream, one packet per frame, for the image-processing pipeline. It measures active frame dimensions, counts frames and flags overflow. The sink may stall; the video side never stalls.

---
 rtl/cvi_pkg.sv | 30 +++
 rtl/cvi_fifo.sv | 51 +++++
 rtl/cvi_stream_rx.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/cvi_pkg.sv
// Shared types and constants for the clocked-video stream receiver.
// Holds the pixel/FIFO-entry layout, the receive FSM state type and the
// sync edge-detect helper.
package cvi_pkg;

  localparam int unsigned PixW   = 24;
  localparam int unsigned EntryW = PixW + 2;

  // Reset value of the previous-sync registers; a sync held high through
  // reset release therefore counts as a rising edge.
  localparam logic SyncIdle = 1'b0;

  typedef struct packed {
    logic            sop;
    logic            eop;
    logic [PixW-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StWaitSop,
    StActive,
    StDrop
  } state_e;

  function automatic logic rise(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/cvi_fifo.sv
// Synchronous show-ahead FIFO. The head entry is presented on rdata_o
// whenever the FIFO is not empty (zero otherwise), straight from the
// storage registers, so a pushed entry is visible the cycle after the push.
// Ports: push_i/wdata_i write side, pop_i read side (ignored when empty),
// full_o/empty_o flags, occ_o current occupancy (0..FIFO_DEPTH).
module cvi_fifo #(
  parameter int unsigned FIFO_DEPTH = 512,
  parameter int unsigned Width      = 26,
  localparam int unsigned Aw        = $clog2(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [Aw:0]      occ_o
);

  logic [Width-1:0] mem_q [FIFO_DEPTH];
  logic [Aw-1:0]    wr_ptr_q, rd_ptr_q;
  logic [Aw:0]      occ_q;
  logic             push_ok, pop_ok;

  assign empty_o = (occ_q == '0);
  assign full_o  = (occ_q == (Aw+1)'(FIFO_DEPTH));
  assign pop_ok  = pop_i & ~empty_o;
  // A push into a full FIFO is only accepted when the head leaves this cycle.
  assign push_ok = push_i & (~full_o | pop_ok);
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign occ_o   = occ_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      occ_q <= occ_q + (Aw+1)'(push_ok) - (Aw+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/cvi_stream_rx.sv
// Clocked-video receiver: repacks a free-running RGB pixel stream
// (datavalid, h_sync, v_sync) into an Avalon-ST packet per frame, measures
// frame dimensions, counts frames and flags FIFO overflow.
// Ports: vid_* video input; source_* Avalon-ST output (readyLatency 0);
// frame_width/frame_height/frame_count status of the last complete frame;
// overflow sticky overflow flag; locked set after the first v_sync edge.
module cvi_stream_rx
  import cvi_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 512,
  parameter int unsigned DIM_W      = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [23:0]      vid_data,
  input  logic             vid_datavalid,
  input  logic             vid_h_sync,
  input  logic             vid_v_sync,
  output logic [23:0]      source_data,
  output logic             source_valid,
  input  logic             source_ready,
  output logic             source_startofpacket,
  output logic             source_endofpacket,
  output logic [DIM_W-1:0] frame_width,
  output logic [DIM_W-1:0] frame_height,
  output logic [15:0]      frame_count,
  output logic             overflow,
  output logic             locked
);

  localparam int unsigned      OccW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [OccW-1:0]  BodyLimit = OccW'(FIFO_DEPTH - 1);
  localparam logic [OccW-1:0]  EopLimit  = OccW'(FIFO_DEPTH);
  localparam logic [DIM_W-1:0] DimMax    = '1;

  state_e            state_q, state_d;
  entry_t            hold_q, hold_d;
  entry_t            push_entry_q, push_entry_d;
  logic              push_q, push_d;
  logic              vs_prev_q, hs_prev_q;
  logic              vs_rise, hs_rise;
  logic              overflow_q, overflow_d, locked_q, locked_d;
  logic              close_ok;
  logic [DIM_W-1:0]  col_q, col_d, row_q, row_d, line_w_q, line_w_d;
  logic [DIM_W-1:0]  width_q, width_d, height_q, height_d;
  logic [15:0]       count_q, count_d;
  logic [OccW-1:0]   fifo_occ, occ_eff;
  logic              fifo_full, fifo_empty, fifo_pop, lost;
  entry_t            head;

  assign vs_rise = rise(vid_v_sync, vs_prev_q);
  assign hs_rise = rise(vid_h_sync, hs_prev_q);

  // Occupancy as seen by the next push: includes the push still in flight.
  assign occ_eff  = fifo_occ + OccW'(push_q);
  assign fifo_pop = source_valid & source_ready;
  assign lost     = push_q & fifo_full & ~fifo_pop;

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    push_d       = 1'b0;
    push_entry_d = hold_q;
    overflow_d   = overflow_q | lost;
    locked_d     = locked_q;
    close_ok     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (vs_rise) begin
          state_d  = StWaitSop;
          locked_d = 1'b1;
        end
      end
      StWaitSop: begin
        if (vid_datavalid) begin
          hold_d  = entry_t'{sop: 1'b1, eop: 1'b0, data: vid_data};
          state_d = StActive;
        end
      end
      StActive: begin
        if (vs_rise) begin
          push_d           = 1'b1;
          push_entry_d.eop = 1'b1;
          if (occ_eff < EopLimit) close_ok = 1'b1;
          else                    overflow_d = 1'b1;
          // A coincident pixel opens the next frame immediately.
          if (vid_datavalid) hold_d = entry_t'{sop: 1'b1, eop: 1'b0, data: vid_data};
          else               state_d = StWaitSop;
        end else if (vid_datavalid) begin
          push_d = 1'b1;
          hold_d = entry_t'{sop: 1'b0, eop: 1'b0, data: vid_data};
          // Last free slot is kept for the terminating beat.
          if (occ_eff >= BodyLimit) begin
            push_entry_d.eop = 1'b1;
            overflow_d       = 1'b1;
            state_d          = StDrop;
          end
        end
      end
      StDrop: begin
        if (vs_rise) state_d = StWaitSop;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    line_w_d = line_w_q;
    width_d  = width_q;
    height_d = height_q;
    count_d  = count_q;
    if (close_ok) begin
      width_d  = line_w_q;
      height_d = (col_q != '0 && row_q != DimMax) ? row_q + 1'b1 : row_q;
      count_d  = count_q + 16'd1;
    end
    if (vs_rise) begin
      row_d    = '0;
      line_w_d = '0;
      col_d    = vid_datavalid ? DIM_W'(1) : '0;
    end else if (hs_rise) begin
      if (col_q != '0) begin
        row_d    = (row_q != DimMax) ? row_q + 1'b1 : row_q;
        line_w_d = col_q;
      end
      col_d = vid_datavalid ? DIM_W'(1) : '0;
    end else if (vid_datavalid && col_q != DimMax) begin
      col_d = col_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      hold_q       <= '0;
      push_q       <= 1'b0;
      push_entry_q <= '0;
      vs_prev_q    <= SyncIdle;
      hs_prev_q    <= SyncIdle;
      overflow_q   <= 1'b0;
      locked_q     <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      line_w_q     <= '0;
      width_q      <= '0;
      height_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      push_q       <= push_d;
      push_entry_q <= push_entry_d;
      vs_prev_q    <= vid_v_sync;
      hs_prev_q    <= vid_h_sync;
      overflow_q   <= overflow_d;
      locked_q     <= locked_d;
      col_q        <= col_d;
      row_q        <= row_d;
      line_w_q     <= line_w_d;
      width_q      <= width_d;
      height_q     <= height_d;
      count_q      <= count_d;
    end
  end

  cvi_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .Width     (EntryW)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (push_q),
    .wdata_i(push_entry_q),
    .pop_i  (fifo_pop),
    .rdata_o(head),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .occ_o  (fifo_occ)
  );

  assign source_valid         = ~fifo_empty;
  assign source_data          = head.data;
  assign source_startofpacket = head.sop;
  assign source_endofpacket   = head.eop;
  assign frame_width          = width_q;
  assign frame_height         = height_q;
  assign frame_count          = count_q;
  assign overflow             = overflow_q;
  assign locked               = locked_q;

endmodule
